// File: rtl/reg_alu_engine.sv
// Parametrised register-file ALU with a valid/ready command port and a shift-add multiply.
// Optional flag output is enabled by defining REG_ALU_FLAGS_EN.
module reg_alu_engine #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned NREGS = 4,
  localparam int unsigned AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    rd_addr,
  input  logic [AW-1:0]    we_addr,
  input  logic [WIDTH-1:0] immediate,
  input  logic [2:0]       control,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic             out_valid,
  output logic [AW-1:0]    out_addr,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       flags
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_ANDN = 3'b100;
  localparam logic [2:0] OP_ORN  = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  logic [0:0]         state_q, state_d;
  logic [WIDTH-1:0]   regs_q [NREGS];
  logic [WIDTH-1:0]   regs_d [NREGS];
  logic [2*WIDTH-1:0] mul_a_q, mul_a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [AW-1:0]      mul_dst_q, mul_dst_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [AW-1:0]      out_addr_q, out_addr_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;

  logic               accept;
  logic               mul_last;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   alu_res;
  logic [2*WIDTH-1:0] mul_sum;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign op_a      = regs_q[rd_addr];
  assign dbg_data  = regs_q[dbg_addr];
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;

  // One multiplier bit per cycle: add the shifted multiplicand when B's LSB is set.
  assign mul_sum  = acc_q + (mul_b_q[0] ? mul_a_q : '0);
  assign mul_last = (state_q == S_MUL) && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    alu_res = '0;
    case (control)
      OP_AND:  alu_res = op_a & immediate;
      OP_OR:   alu_res = op_a | immediate;
      OP_ADD:  alu_res = op_a + immediate;
      OP_ANDN: alu_res = op_a & ~immediate;
      OP_ORN:  alu_res = op_a | ~immediate;
      OP_SUB:  alu_res = op_a - immediate;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(immediate))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_dst_d   = mul_dst_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (control == OP_MUL) begin
            mul_a_d   = {{WIDTH{1'b0}}, op_a};
            mul_b_d   = immediate;
            mul_dst_d = we_addr;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = S_MUL;
          end else begin
            regs_d[we_addr] = alu_res;
            out_valid_d     = 1'b1;
            out_addr_d      = we_addr;
            out_data_d      = alu_res;
          end
        end
      end
      S_MUL: begin
        acc_d   = mul_sum;
        mul_a_d = mul_a_q << 1;
        mul_b_d = mul_b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (mul_last) begin
          regs_d[mul_dst_q] = mul_sum[WIDTH-1:0];
          out_valid_d       = 1'b1;
          out_addr_d        = mul_dst_q;
          out_data_d        = mul_sum[WIDTH-1:0];
          state_d           = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      regs_q      <= '{default: '0};
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_dst_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      mul_dst_q   <= mul_dst_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef REG_ALU_FLAGS_EN
  logic [2:0] flags_q, flags_d;

  // Flags follow the register write; add carry-out shows up as a wrapped sum below A.
  always_comb begin
    flags_d = flags_q;
    if (accept && (control != OP_MUL)) begin
      flags_d = {(alu_res == '0), 1'b0, 1'b0};
      if (control == OP_ADD) begin
        flags_d[1] = (alu_res < op_a);
        flags_d[0] = (op_a[WIDTH-1] == immediate[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end else if (control == OP_SUB) begin
        flags_d[1] = (op_a >= immediate);
        flags_d[0] = (op_a[WIDTH-1] != immediate[WIDTH-1]) && (alu_res[WIDTH-1] != op_a[WIDTH-1]);
      end
    end else if (mul_last) begin
      flags_d = {(mul_sum[WIDTH-1:0] == '0), |mul_sum[2*WIDTH-1:WIDTH], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) flags_q <= '0;
    else     flags_q <= flags_d;
  end

  assign flags = flags_q;
`else
  assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_reg_alu_engine.sv
// Self-checking bench for reg_alu_engine (WIDTH=4, NREGS=4): directed table, multiply/reset corners, random commands.
module tb_reg_alu_engine;

  localparam int W = 4;
  localparam int N = 4;

  logic       clk, rst, in_valid, in_ready, out_valid;
  logic [1:0] rd_addr, we_addr, dbg_addr, out_addr;
  logic [3:0] immediate, dbg_data, out_data;
  logic [2:0] control, flags;

  int checks, errors;
  logic [3:0] m_regs [N];
  logic [2:0] m_flags;

  typedef struct {
    logic [1:0] rd;
    logic [1:0] we;
    logic [3:0] imm;
    logic [2:0] op;
    logic [3:0] exp;
  } vec_t;
  vec_t tbl [12];

  reg_alu_engine #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rd_addr(rd_addr), .we_addr(we_addr), .immediate(immediate), .control(control),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .out_valid(out_valid),
    .out_addr(out_addr), .out_data(out_data), .flags(flags)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference result {zero, carry, overflow, result} from plain integer arithmetic.
  function automatic logic [6:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int ia, ib, sa, sb, s;
    logic [3:0] r;
    logic c, v;
    ia = int'(a);
    ib = int'(b);
    sa = (ia > 7) ? ia - 16 : ia;
    sb = (ib > 7) ? ib - 16 : ib;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin s = ia + ib; r = 4'(s); c = (s > 15); v = (sa + sb > 7) || (sa + sb < -8); end
      3'd3: begin s = ia * ib; r = 4'(s); c = (s > 15); end
      3'd4: r = a & ~b;
      3'd5: r = a | ~b;
      3'd6: begin s = ia - ib; r = 4'(s); c = (ia >= ib); v = (sa - sb > 7) || (sa - sb < -8); end
      default: r = (sa < sb) ? 4'd1 : 4'd0;
    endcase
    return {(r == 4'd0), c, v, r};
  endfunction

  task automatic run_cmd(input logic [1:0] rd, input logic [1:0] we, input logic [3:0] imm,
                         input logic [2:0] op, output logic [3:0] got);
    logic [6:0] rr;
    rr = ref_op(m_regs[rd], imm, op);
    rd_addr = rd; we_addr = we; immediate = imm; control = op; in_valid = 1'b1; dbg_addr = we;
    #1;
    check("ready_before_accept", in_ready, 1);
    check("dbg_prewrite", dbg_data, m_regs[we]);
    tick();
    if (op == 3'd3) begin
      for (int k = 0; k < W; k++) begin
        check("mul_busy_ready", in_ready, 0);
        check("mul_busy_out_valid", out_valid, 0);
        check("mul_busy_nowrite", dbg_data, m_regs[we]);
        tick();
      end
    end
    in_valid = 1'b0;
    check("out_valid", out_valid, 1);
    check("out_addr", out_addr, we);
    check("out_data", out_data, rr[3:0]);
`ifdef REG_ALU_FLAGS_EN
    m_flags = rr[6:4];
`endif
    check("flags", flags, m_flags);
    m_regs[we] = rr[3:0];
    check("dbg_postwrite", dbg_data, m_regs[we]);
    got = out_data;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    rd_addr = 2'($urandom); we_addr = 2'($urandom); immediate = 4'($urandom); control = 3'($urandom);
    dbg_addr = 2'($urandom);
    tick();
    check("idle_out_valid", out_valid, 0);
    check("idle_flags_hold", flags, m_flags);
    check("idle_dbg", dbg_data, m_regs[dbg_addr]);
  endtask

  initial begin
    logic [3:0] got;
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0;
    rd_addr = '0; we_addr = '0; dbg_addr = '0; immediate = '0; control = '0;
    checks = 0; errors = 0; m_flags = '0;
    for (int i = 0; i < N; i++) m_regs[i] = '0;

    tbl[0]  = '{rd: 2'd0, we: 2'd1, imm: 4'h7, op: 3'd2, exp: 4'h7};
    tbl[1]  = '{rd: 2'd1, we: 2'd2, imm: 4'hB, op: 3'd2, exp: 4'h2};
    tbl[2]  = '{rd: 2'd1, we: 2'd0, imm: 4'h8, op: 3'd7, exp: 4'h0};
    tbl[3]  = '{rd: 2'd0, we: 2'd3, imm: 4'hF, op: 3'd1, exp: 4'hF};
    tbl[4]  = '{rd: 2'd3, we: 2'd0, imm: 4'h1, op: 3'd7, exp: 4'h1};
    tbl[5]  = '{rd: 2'd1, we: 2'd0, imm: 4'h9, op: 3'd6, exp: 4'hE};
    tbl[6]  = '{rd: 2'd3, we: 2'd2, imm: 4'hC, op: 3'd0, exp: 4'hC};
    tbl[7]  = '{rd: 2'd2, we: 2'd0, imm: 4'hA, op: 3'd0, exp: 4'h8};
    tbl[8]  = '{rd: 2'd2, we: 2'd0, imm: 4'hA, op: 3'd1, exp: 4'hE};
    tbl[9]  = '{rd: 2'd2, we: 2'd0, imm: 4'hA, op: 3'd4, exp: 4'h4};
    tbl[10] = '{rd: 2'd2, we: 2'd0, imm: 4'hA, op: 3'd5, exp: 4'hD};
    tbl[11] = '{rd: 2'd2, we: 2'd2, imm: 4'h3, op: 3'd2, exp: 4'hF};

    // Reset state
    tick(); tick();
    check("ready_in_reset", in_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", in_ready, 1);
    check("out_valid_after_reset", out_valid, 0);
    check("flags_after_reset", flags, 0);
    for (int i = 0; i < N; i++) begin
      dbg_addr = 2'(i);
      #1;
      check($sformatf("reset_dbg%0d", i), dbg_data, 0);
    end

    // Back-to-back directed table
    for (int i = 0; i < 12; i++) begin
      run_cmd(tbl[i].rd, tbl[i].we, tbl[i].imm, tbl[i].op, got);
      check($sformatf("tbl%0d_data", i), got, tbl[i].exp);
    end
    idle_cycle();

    // Multiply with in_valid held through the busy window: 7*3 = 21 -> 5
    run_cmd(2'd1, 2'd3, 4'h3, 3'd3, got);
    check("mul_7x3", got, 4'h5);
    idle_cycle();
    idle_cycle();

    // Reset two cycles into a multiply
    rd_addr = 2'd1; we_addr = 2'd2; immediate = 4'h3; control = 3'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("ready_during_reset", in_ready, 0);
    rst = 1'b0;
    #1;
    check("ready_after_abort", in_ready, 1);
    for (int i = 0; i < N; i++) m_regs[i] = '0;
    m_flags = '0;
    for (int i = 0; i < 6; i++) idle_cycle();
    dbg_addr = 2'd2;
    #1;
    check("abort_no_write", dbg_data, 0);

    // Random commands with random idle gaps
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      run_cmd(2'($urandom), 2'($urandom), 4'($urandom), 3'($urandom), got);
    end
    idle_cycle();
    for (int i = 0; i < N; i++) begin
      dbg_addr = 2'(i);
      #1;
      check($sformatf("final_dbg%0d", i), dbg_data, m_regs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_alu_engine.md
Name: reg_alu_engine

Overview:
- Parametrised successor to the 4-bit, 4-register calculator.
- Holds NREGS registers of WIDTH bits. Each accepted command computes reg[rd_addr] OP immediate and writes the result to reg[we_addr].
- Adds a valid/ready command handshake, synchronous reset, a result strobe, and a multi-cycle shift-add multiply on the previously unused opcode.
- Sits between the command sequencer and the register-file debug/readout path.

Parameters:
- WIDTH, 4, operand/register width in bits (>=2).
- NREGS, 4, number of registers (power of two, >=2); localparam AW = $clog2(NREGS).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  engine can accept a command.
- rd_addr  in  AW  source register index.
- we_addr  in  AW  destination register index.
- immediate  in  WIDTH  second operand.
- control  in  3  opcode.
- dbg_addr  in  AW  debug read index.
- dbg_data  out  WIDTH  combinational reg[dbg_addr].
- out_valid  out  1  one-cycle result strobe.
- out_addr  out  AW  destination of the reported result.
- out_data  out  WIDTH  value written.
- flags  out  3  {zero, carry, overflow}; see Optional Feature.

Behaviour:
- Opcodes (A = reg[rd_addr], B = immediate):
  - 000 A&B
  - 001 A|B
  - 010 A+B
  - 011 A*B (low WIDTH bits, multi-cycle)
  - 100 A&~B
  - 101 A|~B
  - 110 A-B
  - 111 SLT: 1 if A<B as two's-complement signed, else 0, zero-extended.
- Add and subtract wrap modulo 2^WIDTH.
- Accept: in_valid && in_ready sampled at posedge. A is read combinationally in the accepting cycle.
- FSM states: IDLE, MUL.
  - IDLE: in_ready=1. A single-cycle op writes reg[we_addr] at the accepting edge. The next cycle shows out_valid=1 with out_addr=we_addr and out_data=result. Latency 1. Back-to-back accepts are allowed every cycle; the second command reads the value written by the first (write happens at the edge, so no hazard).
  - IDLE, opcode 011: the accepting edge captures A, B and we_addr, clears the accumulator and goes to MUL. No write at this edge.
  - MUL: in_ready=0. One shift-add step per cycle over WIDTH cycles, LSB of B first. After the WIDTH-th step, the accumulator's low WIDTH bits are written to the captured we_addr, out_valid is pulsed and the FSM returns to IDLE. Latency from accept to out_valid = WIDTH+1 cycles.
  - in_valid while in_ready=0 is ignored; the command is not queued and the sender must hold it.
- rd_addr==we_addr is legal: the old value is used as A and the new value is written.
- Command inputs are "don't care" when in_valid=0. No register changes without an accepted command.
- Reset (any state, including mid-MUL):
  - all registers 0, state IDLE, out_valid 0, out_addr 0, out_data 0, flags 0, accumulator 0.
  - An aborted multiply writes nothing.
  - in_ready=0 while rst=1, and 1 in the first cycle after.
- dbg_data is purely combinational. In the accepting cycle it shows the pre-write value.

Optional Feature:
- Macro: REG_ALU_FLAGS_EN.
- Defined: flags is registered and updated on the same edge as the register write (visible with out_valid).
  - zero = result==0.
  - carry = carry-out for add; borrow-not (A>=B unsigned) for sub; OR of the discarded high product bits for mul; 0 otherwise.
  - overflow = signed overflow for add/sub; 0 otherwise.
- Not defined: flags is constant 0 and no flag logic is synthesised.

Test Plan (WIDTH=4, NREGS=4):
1. Reset, then dbg_addr 0..3 -> dbg_data=0 everywhere; in_ready=1, out_valid=0.
2. Accept (rd=0, we=1, imm=7, op 010), then (rd=1, we=2, imm=0xB, op 010) on consecutive cycles -> reg1=7 and reg2=2 (wrap). out_valid pulses two consecutive cycles with (1,7) then (2,2). With FLAGS_EN the second strobe shows carry=1, overflow=0.
3. reg1=7; op 111 with imm=0x8 -> 0 (7 is not < -8); op 111 with reg3=0xF and imm=1 -> 1; op 110 with rd=1, imm=9 -> 0xE.
4. reg1=7; op 011, imm=3, we=3 -> in_ready low exactly 4 cycles; in_valid held high meanwhile is not accepted; out_valid 5 cycles after accept with (3,0x5). With FLAGS_EN carry=1.
5. Start op 011, assert rst 2 cycles later -> no write to destination, out_valid never pulses, in_ready=1 in the cycle after rst deasserts.
6. ops 000/001/100/101 on A=0xC, B=0xA -> 0x8, 0xE, 0x4, 0xD respectively.
